// File: rtl/fir_pkg.sv
// Shared constants for the multi-channel FIR block.
// Holds the default parameter values used by the top and the channel datapath,
// the fixed input-to-output latency, and a helper for the full-precision width.
package fir_pkg;

  localparam int DEF_NUM_CH   = 3;
  localparam int DEF_NUM_TAPS = 8;
  localparam int DEF_DIN_W    = 16;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_DOUT_W   = 64;

  // Rising edges between the edge that accepts a sample and the edge that
  // presents its result on out_valid/dout.
  localparam int PIPE_LAT = 3;

  // Width of an exact y[n]: one product plus enough guard bits for the tap sum.
  function automatic int full_width(input int din_w, input int coef_w, input int taps);
    return din_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_channel.sv
// One channel of the FIR datapath.
// Stages: delay line (advances only when adv_i), registered tap products,
// registered saturated tap sum (or the bypassed sample), then a held output
// register that loads only when the top says the sum stage carries a sample.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   adv_i           accept x_i into the delay line this cycle
//   bypass_i        sample accepted with adv_i is passed through unfiltered
//   x_i             signed input sample
//   coef_i          active coefficient set, tap k at [k*COEF_W +: COEF_W]
//   ld_out_i        sum stage holds a valid sample; load it into dout_o
//   dout_o          held signed result
//   sat_o           sum stage result was clipped (meaningful with ld_out_i)
module fir_channel
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int DIN_W    = DEF_DIN_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int DOUT_W   = DEF_DOUT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv_i,
  input  logic                       bypass_i,
  input  logic [DIN_W-1:0]           x_i,
  input  logic [NUM_TAPS*COEF_W-1:0] coef_i,
  input  logic                       ld_out_i,
  output logic [DOUT_W-1:0]          dout_o,
  output logic                       sat_o
);

  localparam int PW = DIN_W + COEF_W;
  localparam int FW = full_width(DIN_W, COEF_W, NUM_TAPS);
  // Comparison width: wide enough for both the exact sum and the output range.
  localparam int EW = (FW > DOUT_W) ? FW : DOUT_W;
  localparam logic signed [EW-1:0] SAT_HI = {{(EW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_LO = {{(EW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  // When the exact width already fits DOUT_W these never trigger and the
  // result is a plain sign extension.
  function automatic logic is_sat(input logic signed [FW-1:0] v);
    logic signed [EW-1:0] ext;
    ext = EW'(v);
    return (ext > SAT_HI) || (ext < SAT_LO);
  endfunction

  function automatic logic signed [DOUT_W-1:0] sat_out(input logic signed [FW-1:0] v);
    logic signed [EW-1:0] ext;
    ext = EW'(v);
    if (ext > SAT_HI) return SAT_HI[DOUT_W-1:0];
    if (ext < SAT_LO) return SAT_LO[DOUT_W-1:0];
    return ext[DOUT_W-1:0];
  endfunction

  logic signed [DIN_W-1:0]  dly_p0 [NUM_TAPS];
  logic                     byp_p0;
  logic signed [PW-1:0]     prod_p1 [NUM_TAPS];
  logic signed [DIN_W-1:0]  x_p1;
  logic                     byp_p1;
  logic signed [FW-1:0]     acc_p1;
  logic signed [DOUT_W-1:0] sum_p2;
  logic                     sat_p2;
  logic signed [DOUT_W-1:0] dout_q;

  // Stage p0: delay line, dly_p0[0] is the newest sample
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS; k++) dly_p0[k] <= '0;
      byp_p0 <= 1'b0;
    end else if (adv_i) begin
      dly_p0[0] <= x_i;
      for (int k = 1; k < NUM_TAPS; k++) dly_p0[k] <= dly_p0[k-1];
      byp_p0 <= bypass_i;
    end
  end

  // Stage p1: products use whatever coefficient set is active at this edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS; k++) prod_p1[k] <= '0;
      x_p1   <= '0;
      byp_p1 <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_TAPS; k++)
        prod_p1[k] <= PW'(dly_p0[k]) * PW'($signed(coef_i[k*COEF_W +: COEF_W]));
      x_p1   <= dly_p0[0];
      byp_p1 <= byp_p0;
    end
  end

  always_comb begin
    acc_p1 = '0;
    for (int k = 0; k < NUM_TAPS; k++) acc_p1 = acc_p1 + FW'(prod_p1[k]);
  end

  // Stage p2: saturated sum, or the bypassed sample sign-extended
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_p2 <= '0;
      sat_p2 <= 1'b0;
    end else if (byp_p1) begin
      sum_p2 <= DOUT_W'(x_p1);
      sat_p2 <= 1'b0;
    end else begin
      sum_p2 <= sat_out(acc_p1);
      sat_p2 <= is_sat(acc_p1);
    end
  end

  // Output register holds its value between valid results
  always_ff @(posedge clk) begin
    if (!rst)          dout_q <= '0;
    else if (ld_out_i) dout_q <= sum_p2;
  end

  assign dout_o = dout_q;
  assign sat_o  = sat_p2;

endmodule

// File: rtl/multi_channel_fir.sv
// Multi-channel FIR filter with a shared, double-buffered coefficient set.
// All channels accept a sample together on in_valid; each result appears
// PIPE_LAT edges later with out_valid. Coefficients are written into a shadow
// bank and copied into the active bank on coef_commit.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   in_valid, din               per-cycle sample strobe, packed signed samples
//   bypass                      pass samples through instead of filtering
//   coef_we/addr/data           shadow coefficient write
//   coef_commit                 shadow (including a same-cycle write) -> active
//   out_valid, dout             result strobe and packed held results
//   sat_flag                    sticky per-channel saturation indicator
module multi_channel_fir
  import fir_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int DIN_W    = DEF_DIN_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int DOUT_W   = DEF_DOUT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [NUM_CH*DIN_W-1:0]     din,
  input  logic                        bypass,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]           coef_data,
  input  logic                        coef_commit,
  output logic                        out_valid,
  output logic [NUM_CH*DOUT_W-1:0]    dout,
  output logic [NUM_CH-1:0]           sat_flag
);

  logic [COEF_W-1:0]          shadow_q [NUM_TAPS];
  logic [COEF_W-1:0]          shadow_d [NUM_TAPS];
  logic [COEF_W-1:0]          active_q [NUM_TAPS];
  logic [NUM_TAPS*COEF_W-1:0] coef_flat;

  logic vld_p0, vld_p1, vld_p2, vld_p3;
  logic [NUM_CH-1:0] ch_sat;
  logic [NUM_CH-1:0] sat_q;

  // The commit copies shadow_d rather than shadow_q so a write in the commit
  // cycle lands in the active bank too.
  always_comb begin
    shadow_d = shadow_q;
    if (coef_we) shadow_d[coef_addr] = coef_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= (k == 0) ? COEF_W'(1) : '0;
        active_q[k] <= (k == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (coef_commit) active_q <= shadow_d;
    end
  end

  always_comb begin
    coef_flat = '0;
    for (int k = 0; k < NUM_TAPS; k++) coef_flat[k*COEF_W +: COEF_W] = active_q[k];
  end

  // Valid travels one register per datapath stage; vld_p3 is out_valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      sat_q  <= '0;
    end else begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      sat_q  <= sat_q | ({NUM_CH{vld_p2}} & ch_sat);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fir_channel #(
      .NUM_TAPS (NUM_TAPS),
      .DIN_W    (DIN_W),
      .COEF_W   (COEF_W),
      .DOUT_W   (DOUT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .adv_i    (in_valid),
      .bypass_i (bypass),
      .x_i      (din[c*DIN_W +: DIN_W]),
      .coef_i   (coef_flat),
      .ld_out_i (vld_p2),
      .dout_o   (dout[c*DOUT_W +: DOUT_W]),
      .sat_o    (ch_sat[c])
    );
  end

  assign out_valid = vld_p3;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_multi_channel_fir.sv
`timescale 1ns/1ps
module tb_multi_channel_fir;
  import fir_pkg::*;

  localparam int NCH = 3;
  localparam int NT  = 8;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int OWA = 64;
  localparam int OWB = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, bypass, coef_we, coef_commit;
  logic [NCH*DW-1:0] din;
  logic [2:0]        coef_addr;
  logic [CW-1:0]     coef_data;
  logic              ov_a, ov_b;
  logic [NCH*OWA-1:0] dout_a;
  logic [NCH*OWB-1:0] dout_b;
  logic [NCH-1:0]    sat_a, sat_b;

  multi_channel_fir #(.NUM_CH(NCH), .NUM_TAPS(NT), .DIN_W(DW), .COEF_W(CW), .DOUT_W(OWA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .bypass(bypass),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
    .out_valid(ov_a), .dout(dout_a), .sat_flag(sat_a));

  multi_channel_fir #(.NUM_CH(NCH), .NUM_TAPS(NT), .DIN_W(DW), .COEF_W(CW), .DOUT_W(OWB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .bypass(bypass),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
    .out_valid(ov_b), .dout(dout_b), .sat_flag(sat_b));

  typedef struct {
    logic [NCH-1:0][63:0] y;
    bit                   byp;
    int                   due;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     failures = 0;
  int     edges = 0;
  bit     mon_en = 1'b0;

  // Reference state: sample history per channel (index 0 newest) and the banks
  longint hist [NCH][NT];
  int     sh [NT];
  int     act [NT];
  logic [NCH-1:0] msat_a, msat_b;
  longint last_a [NCH];
  longint last_b [NCH];

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, $signed(a), $signed(e));
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    if (w >= 64) return v;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [NCH*DW-1:0] pack3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NT; k++) hist[c][k] = 0;
      last_a[c] = 0;
      last_b[c] = 0;
    end
    for (int k = 0; k < NT; k++) begin
      sh[k]  = (k == 0) ? 1 : 0;
      act[k] = (k == 0) ? 1 : 0;
    end
    msat_a = '0;
    msat_b = '0;
  endtask

  // One clock of stimulus; the reference is updated with what the edge sampled
  task automatic step(input bit v, input bit byp, input logic [NCH*DW-1:0] d,
                      input bit we, input int addr, input int data, input bit cm, input bit rn);
    exp_t e;
    rst = rn; in_valid = v; bypass = byp; din = d;
    coef_we = we; coef_addr = addr[2:0]; coef_data = data[15:0]; coef_commit = cm;
    @(posedge clk);
    #1;
    if (!rn) begin
      model_reset();
    end else begin
      if (we) sh[addr] = data;
      if (cm) act = sh;
      if (v) begin
        for (int c = 0; c < NCH; c++) begin
          longint s;
          for (int k = NT - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
          hist[c][0] = longint'($signed(d[c*DW +: DW]));
          s = 0;
          for (int k = 0; k < NT; k++) s += longint'(act[k]) * hist[c][k];
          e.y[c] = byp ? hist[c][0] : s;
        end
        e.byp = byp;
        e.due = edges + PIPE_LAT;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 1);
  endtask

  task automatic samp(input logic [NCH*DW-1:0] d, input bit byp);
    step(1, byp, d, 0, 0, 0, 0, 1);
  endtask

  task automatic wcoef(input int addr, input int data);
    step(0, 0, '0, 1, addr, data, 0, 1);
  endtask

  // Monitor: pops the scoreboard when a result is due, otherwise checks holds
  always @(negedge clk) begin : mon
    bit     exp_v;
    exp_t   e;
    longint y, yb;
    if (mon_en) begin
      while (q.size() > 0 && q[0].due < edges) begin
        chk("missed_output_due", 64'(edges), 64'(q[0].due));
        q.delete(0);
      end
      exp_v = (q.size() > 0 && q[0].due == edges);
      chk("out_valid_a", 64'(ov_a), 64'(exp_v));
      chk("out_valid_b", 64'(ov_b), 64'(exp_v));
      if (exp_v) begin
        e = q.pop_front();
        for (int c = 0; c < NCH; c++) begin
          y  = longint'(e.y[c]);
          yb = e.byp ? y : clamp(y, OWB);
          last_a[c] = y;
          last_b[c] = yb;
          if (!e.byp && yb != y) msat_b[c] = 1'b1;
          if (!e.byp && clamp(y, OWA) != y) msat_a[c] = 1'b1;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("dout_a_ch%0d", c), dout_a[c*OWA +: OWA], 64'(last_a[c]));
        chk($sformatf("dout_b_ch%0d", c), 64'($signed(dout_b[c*OWB +: OWB])), 64'(last_b[c]));
      end
      chk("sat_flag_a", 64'(sat_a), 64'(msat_a));
      chk("sat_flag_b", 64'(sat_b), 64'(msat_b));
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; bypass = 1'b0; din = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    step(0, 0, '0, 0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    idle(2);

    // Identity coefficients after reset
    samp(pack3(100, -5, 32767), 0);
    idle(5);

    // Coefficients 1,2,3,4,0..; tap 3 written in the commit cycle itself
    for (int k = 0; k < NT; k++) if (k != 3) wcoef(k, (k < 4) ? k + 1 : 0);
    step(0, 0, '0, 1, 3, 4, 1, 1);
    samp(pack3(1, 0, 0), 0);
    for (int i = 0; i < 7; i++) samp(pack3(0, 0, 0), 0);
    idle(5);

    // Gapped input: results follow the same gaps, idle cycles insert nothing
    samp(pack3(1, 1, 1), 0); idle(1);
    samp(pack3(1, 1, 1), 0); idle(6);

    // Bypass one sample, then resume filtering with history intact
    samp(pack3(-7, -7, -7), 1);
    samp(pack3(2, 3, 4), 0);
    idle(5);

    // Shadow writes alone must not disturb filtering
    wcoef(0, 9); wcoef(5, -3);
    for (int i = 0; i < 4; i++) samp(pack3(rnd_s16(), rnd_s16(), rnd_s16()), 0);
    step(1, 0, pack3(rnd_s16(), rnd_s16(), rnd_s16()), 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) samp(pack3(rnd_s16(), rnd_s16(), rnd_s16()), 0);
    idle(4);

    // Randomized traffic with coefficient updates in flight
    for (int i = 0; i < 300; i++) begin
      bit v, byp, we, cm;
      int data;
      v    = ($urandom_range(0, 3) != 0);
      byp  = ($urandom_range(0, 7) == 0);
      we   = ($urandom_range(0, 3) == 0);
      cm   = ($urandom_range(0, 11) == 0);
      data = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) - 8 : rnd_s16();
      step(v, byp, pack3(rnd_s16(), rnd_s16(), rnd_s16()), we,
           int'($urandom_range(0, NT - 1)), data, cm, 1);
    end
    idle(5);

    // Saturation: all taps at max, full-scale input held, then zeros
    for (int k = 0; k < NT; k++) wcoef(k, 32767);
    step(0, 0, '0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) samp(pack3(32767, 32767, 32767), 0);
    for (int i = 0; i < 10; i++) samp(pack3(0, 0, 0), 0);
    idle(5);

    // Reset with two samples in flight
    samp(pack3(rnd_s16(), rnd_s16(), rnd_s16()), 0);
    samp(pack3(rnd_s16(), rnd_s16(), rnd_s16()), 0);
    step(0, 0, '0, 0, 0, 0, 0, 0);
    idle(6);

    // Identity restored after reset
    samp(pack3(-1234, 42, -32768), 0);
    idle(6);

    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
